player_motion: RTL and testbench

- Game-tick consumer of the dual 70 Hz enable generator.
- On each `tick_update` pulse (driven by clk70_1) it advances player physics: walking, jump, gravity and screen-bound clamping.
- On each `tick_commit` pulse (driven by clk70_2, half a period later) it copies the working position into display-facing output registers, so the renderer never sees a mid-update value.
- Sits between the rate generator / button synchroniser and the sprite renderer.

---
 rtl/player_motion.sv | 113 +++++++++++
 tb/tb_player_motion.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// player_motion: tick-driven walk/jump/gravity physics with double-buffered display outputs.
// Optional macro PLAYER_DOUBLE_JUMP_EN allows one extra jump while airborne.
module player_motion #(
    parameter int SCREEN_W  = 640,
    parameter int GROUND_Y  = 448,
    parameter int PLAYER_W  = 16,
    parameter int PLAYER_H  = 16,
    parameter int X_INIT    = 32,
    parameter int WALK_STEP = 2,
    parameter int JUMP_V    = 12,
    parameter int MAX_FALL  = 10
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       tick_update,
    input  logic       tick_commit,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       airborne
);
    localparam logic [1:0] GROUND = 2'd0;
    localparam logic [1:0] RISE   = 2'd1;
    localparam logic [1:0] FALL   = 2'd2;

    localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - PLAYER_W);
    localparam logic signed [11:0] Y_GND = 12'(GROUND_Y - PLAYER_H);
    localparam logic signed [11:0] STEP  = 12'(WALK_STEP);
    localparam logic signed [5:0]  JV    = 6'(JUMP_V);
    localparam logic signed [6:0]  V_MAX = 7'(MAX_FALL);
    localparam logic [9:0]         X_RST = 10'(X_INIT);

    logic [9:0]         x, x_nxt;
    logic signed [10:0] y, y_nxt;
    logic signed [5:0]  vy, vy_nxt;
    logic [1:0]         state, state_nxt;
    logic               jump_prev, jump_edge, air_jump;
    logic signed [11:0] x_step, y_sum;
    logic signed [6:0]  vy_inc, vy_cap;

    assign jump_edge = btn_jump & ~jump_prev;

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic used;
    assign air_jump = jump_edge & ~used;
    always_ff @(posedge clk50M) begin
        if (rst) used <= 1'b0;
        else if (tick_update) used <= (state_nxt == GROUND) ? 1'b0 : used | (air_jump & (state != GROUND));
    end
`else
    assign air_jump = 1'b0;
`endif

    // Widened signed arithmetic so clamps never see a wrapped value.
    always_comb begin
        x_step = $signed({2'b00, x}) + ((btn_right & ~btn_left) ? STEP : (btn_left & ~btn_right) ? -STEP : 12'sd0);
        x_nxt = (x_step < 12'sd0) ? 10'd0 : (x_step > X_MAX) ? X_MAX[9:0] : x_step[9:0];
        y_sum = {y[10], y} + {{6{vy[5]}}, vy};
        vy_inc = {vy[5], vy} + 7'sd1;
        vy_cap = (vy_inc > V_MAX) ? V_MAX : vy_inc;
        y_nxt = y;
        vy_nxt = vy;
        state_nxt = state;
        if (state == GROUND) begin
            vy_nxt = jump_edge ? -JV : 6'sd0;
            state_nxt = jump_edge ? RISE : GROUND;
        end else if (air_jump) begin
            vy_nxt = -JV;
            state_nxt = RISE;
        end else if (y_sum < 12'sd0) begin
            y_nxt = 11'sd0;
            vy_nxt = 6'sd0;
            state_nxt = FALL;
        end else if (y_sum >= Y_GND) begin
            y_nxt = Y_GND[10:0];
            vy_nxt = 6'sd0;
            state_nxt = GROUND;
        end else begin
            y_nxt = y_sum[10:0];
            vy_nxt = vy_cap[5:0];
            state_nxt = (vy_cap >= 7'sd0) ? FALL : state;
        end
    end

    // Commit samples the pre-update working values when both ticks coincide.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            x <= X_RST;
            y <= Y_GND[10:0];
            vy <= 6'sd0;
            state <= GROUND;
            jump_prev <= 1'b0;
            pos_x <= X_RST;
            pos_y <= Y_GND[8:0];
            airborne <= 1'b0;
        end else begin
            if (tick_update) begin
                x <= x_nxt;
                y <= y_nxt;
                vy <= vy_nxt;
                state <= state_nxt;
                jump_prev <= btn_jump;
            end
            if (tick_commit) begin
                pos_x <= x;
                pos_y <= y[8:0];
                airborne <= state != GROUND;
            end
        end
    end
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed test-plan scenarios plus randomized ticks/buttons against a behavioural model.
module tb_player_motion;
    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic       tick_update = 1'b0;
    logic       tick_commit = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       airborne;

    player_motion dut (
        .clk50M(clk50M), .rst(rst), .tick_update(tick_update), .tick_commit(tick_commit),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne)
    );

    always #10 clk50M = ~clk50M;

    int checks = 0;
    int errors = 0;

    int mx, my, mvy, px, py;
    bit in_air, prev_jump, pair;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 32; my = 432; mvy = 0; in_air = 0; prev_jump = 0;
        px = 32; py = 432; pair = 0;
    endtask

    task automatic model_update(input bit l, input bit r, input bit j);
        int ny;
        bit jedge;
        mx = mx + ((r && !l) ? 2 : (l && !r) ? -2 : 0);
        if (mx < 0) mx = 0;
        if (mx > 624) mx = 624;
        jedge = j && !prev_jump;
        prev_jump = j;
        if (!in_air) begin
            mvy = jedge ? -12 : 0;
            in_air = jedge;
        end else begin
            ny = my + mvy;
            if (ny < 0) begin
                my = 0; mvy = 0;
            end else if (ny >= 432) begin
                my = 432; mvy = 0; in_air = 0;
            end else begin
                my = ny;
                mvy = (mvy + 1 > 10) ? 10 : mvy + 1;
            end
        end
    endtask

    task automatic step(input bit u, input bit c, input bit l, input bit r, input bit j, input bit rs);
        @(negedge clk50M);
        tick_update = u; tick_commit = c; btn_left = l; btn_right = r; btn_jump = j; rst = rs;
        @(posedge clk50M);
        #1;
        if (rs) model_reset();
        else begin
            if (c) begin px = mx; py = my; pair = in_air; end
            if (u) model_update(l, r, j);
        end
        check("pos_x", int'(pos_x), px);
        check("pos_y", int'(pos_y), py);
        check("airborne", int'(airborne), int'(pair));
    endtask

    task automatic updates(input int n, input bit l, input bit r, input bit j);
        for (int i = 0; i < n; i++) step(1, 0, l, r, j, 0);
        step(0, 1, l, r, j, 0);
    endtask

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        check("reset_x", int'(pos_x), 32);
        check("reset_y", int'(pos_y), 432);
        check("reset_air", int'(airborne), 0);

        updates(10, 0, 1, 0);
        check("walk10", int'(pos_x), 52);
        updates(400, 0, 1, 0);
        check("clamp_right", int'(pos_x), 624);
        updates(5, 0, 1, 0);
        check("clamp_hold", int'(pos_x), 624);
        updates(3, 1, 1, 0);
        check("both_hold", int'(pos_x), 624);

        updates(1, 0, 0, 1);
        check("jump_tick_y", int'(pos_y), 432);
        check("jump_tick_air", int'(airborne), 1);
        updates(1, 0, 0, 1);
        check("rise1", int'(pos_y), 420);
        updates(1, 0, 0, 1);
        check("rise2", int'(pos_y), 409);
        updates(10, 0, 0, 1);
        check("apex", int'(pos_y), 354);
        updates(1, 0, 0, 1);
        check("fall1", int'(pos_y), 354);
        updates(1, 0, 0, 1);
        check("fall2", int'(pos_y), 355);
        updates(11, 0, 0, 1);
        check("fall13_y", int'(pos_y), 429);
        check("fall13_air", int'(airborne), 1);
        updates(1, 0, 0, 1);
        check("land_y", int'(pos_y), 432);
        check("land_air", int'(airborne), 0);
        updates(5, 0, 0, 1);
        check("held_nojump", int'(airborne), 0);
        updates(1, 0, 0, 0);
        updates(1, 0, 0, 1);
        check("rejump", int'(airborne), 1);

        step(0, 0, 0, 0, 0, 1);
        updates(4, 0, 1, 0);
        check("simul_setup", int'(pos_x), 40);
        step(1, 1, 0, 1, 0, 0);
        check("simul_pre", int'(pos_x), 40);
        step(0, 1, 0, 0, 0, 0);
        check("simul_post", int'(pos_x), 42);

        step(0, 0, 0, 0, 0, 1);
        updates(1, 0, 0, 1);
        updates(5, 0, 0, 0);
        check("midrise_y", int'(pos_y), 382);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        check("rst_mid_y", int'(pos_y), 432);
        check("rst_mid_air", int'(airborne), 0);
        updates(1, 0, 0, 0);
        check("no_residual_y", int'(pos_y), 432);
        check("no_residual_air", int'(airborne), 0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
